proc_mem_axi_arb: RTL and testbench
===================================

Name: proc_mem_axi_arb

Overview:
- Parametrised successor to the single-processor memory-to-AXI bridge.
- Arbitrates NUM_PORTS processor memory ports (ce/we/addr/width/data/ready protocol) onto one AXI4 master using round-robin.
- Issues single-beat AXI transactions with byte-lane steering for 1/2/4/8-byte accesses; AXI ID carries the granted port index.
- Sits between a cluster of proc instances and the shared table-memory interconnect.

Parameters:
- NUM_PORTS, 4, number of processor memory ports (1..16).
- ADDR_W, 32, address width on mem ports and axi_awaddr/axi_araddr.
- DATA_W, 32, mem data and AXI data width (32 or 64).
- ID_W, 4, AXI ID width; must be >= clog2(NUM_PORTS).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-low.
- mem_ce_i  in  NUM_PORTS  per-port request level, held until ready.
- mem_we_i  in  NUM_PORTS  1 = write.
- mem_addr_i  in  NUM_PORTS x ADDR_W  byte address.
- mem_width_i  in  NUM_PORTS x 4  byte count: 1, 2, 4 or 8 (8 only when DATA_W = 64).
- mem_data_i  in  NUM_PORTS x DATA_W  write data, right-aligned.
- mem_data_o  out  NUM_PORTS x DATA_W  read data, right-aligned, zero-extended.
- mem_ready_o  out  NUM_PORTS  one-cycle completion pulse.
- axi_aw*/w*/b*/ar*/r*  AXI4 master channels, full signal set as in the existing bridge.
  - Widths: ID = ID_W, addr = ADDR_W, data = DATA_W, strb = DATA_W/8.

Behaviour:
- Reset (rst = 0 at a clk edge):
  - All *valid, *ready, mem_ready_o, mem_data_o and AXI address/data/strb/id outputs = 0.
  - FSM = IDLE; round-robin pointer = port 0.
  - Reset mid-transaction drops all valids on the next edge; any later AXI response is discarded.
- Constant AXI fields: len = 0, burst = 01 (INCR), lock = 0, cache = 0011, prot = 000, qos = 0.
  - awsize/arsize = log2(width).
- FSM states: IDLE, RADDR, RDATA, WREQ, WRESP, DONE.
- IDLE:
  - Scan mem_ce_i round-robin, starting at (last_grant + 1) mod NUM_PORTS.
  - On a hit, latch we, addr, width and data of that port; grant = k; id = k.
  - Go to RADDR (read) or WREQ (write). Grant decision takes 1 cycle; no request → stay in IDLE.
- RADDR: arvalid = 1, araddr = latched address. On arready: arvalid = 0, rready = 1, go to RDATA.
- RDATA:
  - On rvalid: rready = 0.
  - mem_data_o[k] = (rdata >> 8*addr[OFF-1:0]) masked to width bytes, with OFF = log2(DATA_W/8).
  - Go to DONE.
- WREQ:
  - awvalid and wvalid assert together; wlast = 1.
  - wdata = data << 8*offset; wstrb = ((1 << width) - 1) << offset.
  - Each valid drops independently on its own ready. Both accepted → bready = 1, go to WRESP.
  - Handshakes on both channels in the same cycle are legal.
- WRESP: on bvalid: bready = 0, go to DONE.
- DONE:
  - mem_ready_o[k] = 1 for exactly one cycle; last_grant = k; go to IDLE.
  - The same port cannot be regranted until 1 cycle after DONE.
- Latency with zero-wait AXI: read 4 cycles, write 4 cycles, ce to ready.
- mem_data_o[k] holds its value until port k's next read completes.
- Boundary conditions:
  - ce dropped mid-transaction: the transaction still completes and the ready pulse is still issued.
  - Misaligned access (offset + width > DATA_W/8): address is issued as-is and the strobe is truncated to the bus; no split.
  - Unsupported width value: treated as DATA_W/8.
  - rid/bid are not checked; one transaction is outstanding at a time.
  - Non-OKAY resp: ignored unless the optional feature is enabled.

Optional Feature:
- Macro: PROC_MEM_AXI_ERR_EN.
- Defined:
  - Adds output mem_err_o (NUM_PORTS), a sticky per-port bit set when rresp or bresp != 00 for that port's transaction.
  - Adds input err_clr_i (NUM_PORTS), which clears the matching bits.
  - A read with an error returns mem_data_o = 0. ready is still pulsed.
  - When set and clear hit the same cycle, set wins.
- Undefined: no extra ports; resp is ignored; read data is passed through.

Test Plan:
- Reset with arvalid high mid-read → all outputs 0 on the next edge; FSM returns to IDLE; a later rvalid is ignored.
- Port 2 reads addr 0x1002, width 2, rdata 0xAABBCCDD, zero-wait → araddr 0x1002, arsize 1, arid 2; mem_data_o[2] = 0x0000AABB; ready pulses in cycle 4.
- Port 1 writes 0x000000EE to 0x23, width 1 → wdata 0xEE000000, wstrb 1000, awsize 0; awready delayed 3 cycles, wready immediate; ready pulses one cycle after bvalid.
- Ports 0, 1 and 3 hold ce continuously → grant order 0, 1, 3, 0, 1, 3; no port is starved; each ready pulse lasts exactly 1 cycle.
- With PROC_MEM_AXI_ERR_EN, port 0 reads with rresp = 10 → mem_err_o[0] = 1, mem_data_o[0] = 0; err_clr_i[0] clears the bit; without the macro the data is passed through.

Source files
------------

// File: rtl/proc_mem_axi_arb.sv
`default_nettype none
// =============================================================================
// proc_mem_axi_arb : round-robin arbiter of processor memory ports onto AXI4.
// Optional macro PROC_MEM_AXI_ERR_EN adds sticky per-port response errors.
// Revision: 1.0
// =============================================================================
module proc_mem_axi_arb #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PORTS-1:0]              mem_ce_i,
    input  logic [NUM_PORTS-1:0]              mem_we_i,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  mem_addr_i,
    input  logic [NUM_PORTS-1:0][3:0]         mem_width_i,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]  mem_data_i,
    output logic [NUM_PORTS-1:0][DATA_W-1:0]  mem_data_o,
    output logic [NUM_PORTS-1:0]              mem_ready_o,
`ifdef PROC_MEM_AXI_ERR_EN
    output logic [NUM_PORTS-1:0]              mem_err_o,
    input  logic [NUM_PORTS-1:0]              err_clr_i,
`endif
    output logic [ID_W-1:0]                   axi_awid_o,
    output logic [ADDR_W-1:0]                 axi_awaddr_o,
    output logic [7:0]                        axi_awlen_o,
    output logic [2:0]                        axi_awsize_o,
    output logic [1:0]                        axi_awburst_o,
    output logic                              axi_awlock_o,
    output logic [3:0]                        axi_awcache_o,
    output logic [2:0]                        axi_awprot_o,
    output logic [3:0]                        axi_awqos_o,
    output logic                              axi_awvalid_o,
    input  logic                              axi_awready_i,
    output logic [DATA_W-1:0]                 axi_wdata_o,
    output logic [DATA_W/8-1:0]               axi_wstrb_o,
    output logic                              axi_wlast_o,
    output logic                              axi_wvalid_o,
    input  logic                              axi_wready_i,
    input  logic [ID_W-1:0]                   axi_bid_i,
    input  logic [1:0]                        axi_bresp_i,
    input  logic                              axi_bvalid_i,
    output logic                              axi_bready_o,
    output logic [ID_W-1:0]                   axi_arid_o,
    output logic [ADDR_W-1:0]                 axi_araddr_o,
    output logic [7:0]                        axi_arlen_o,
    output logic [2:0]                        axi_arsize_o,
    output logic [1:0]                        axi_arburst_o,
    output logic                              axi_arlock_o,
    output logic [3:0]                        axi_arcache_o,
    output logic [2:0]                        axi_arprot_o,
    output logic [3:0]                        axi_arqos_o,
    output logic                              axi_arvalid_o,
    input  logic                              axi_arready_i,
    input  logic [ID_W-1:0]                   axi_rid_i,
    input  logic [DATA_W-1:0]                 axi_rdata_i,
    input  logic [1:0]                        axi_rresp_i,
    input  logic                              axi_rlast_i,
    input  logic                              axi_rvalid_i,
    output logic                              axi_rready_o
);

    localparam int          STRB_W    = DATA_W / 8;
    localparam int          OFF       = $clog2(STRB_W);
    localparam int          PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [3:0]  BUS_BYTES = 4'(STRB_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WREQ  = 3'd3,
        S_WRESP = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    function automatic logic [3:0] norm_width(input logic [3:0] w);
        case (w)
            4'd1, 4'd2, 4'd4: norm_width = w;
            4'd8:             norm_width = (STRB_W == 8) ? 4'd8 : BUS_BYTES;
            default:          norm_width = BUS_BYTES;
        endcase
    endfunction

    function automatic logic [2:0] width_to_size(input logic [3:0] w);
        case (w)
            4'd1:    width_to_size = 3'd0;
            4'd2:    width_to_size = 3'd1;
            4'd4:    width_to_size = 3'd2;
            default: width_to_size = 3'd3;
        endcase
    endfunction

    state_t                              state_q;
    logic [PW-1:0]                       ptr_q, grant_q;
    logic [ADDR_W-1:0]                   addr_q;
    logic [ID_W-1:0]                     id_q;
    logic [2:0]                          size_q;
    logic [3:0]                          width_q;
    logic [DATA_W-1:0]                   wdata_q;
    logic [STRB_W-1:0]                   wstrb_q;
    logic                                arvalid_q, awvalid_q, wvalid_q, rready_q, bready_q;
    logic [NUM_PORTS-1:0]                ready_q;
    logic [NUM_PORTS-1:0][DATA_W-1:0]    data_q;

    logic                                hit_d;
    logic [PW-1:0]                       grant_d;
    logic [PW:0]                         idx_d;
    logic [ADDR_W-1:0]                   req_addr_d;
    logic [3:0]                          req_width_d;
    logic [OFF-1:0]                      req_off_d;
    logic [DATA_W-1:0]                   req_wdata_d;
    logic [2*STRB_W-1:0]                 req_strb_d;
    logic [DATA_W-1:0]                   rd_shift_d, rd_fmt_d, rd_data_d;

    // Scan from ptr_q upward; iterating downward lets the nearest requester win.
    always_comb begin
        hit_d   = 1'b0;
        grant_d = '0;
        idx_d   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx_d = {1'b0, ptr_q} + (PW+1)'(i);
            if (idx_d >= (PW+1)'(NUM_PORTS)) begin
                idx_d = idx_d - (PW+1)'(NUM_PORTS);
            end
            if (mem_ce_i[idx_d[PW-1:0]]) begin
                hit_d   = 1'b1;
                grant_d = idx_d[PW-1:0];
            end
        end
    end

    assign req_addr_d  = mem_addr_i[grant_d];
    assign req_width_d = norm_width(mem_width_i[grant_d]);
    assign req_off_d   = req_addr_d[OFF-1:0];
    assign req_wdata_d = mem_data_i[grant_d] << {req_off_d, 3'b000};
    // Wide intermediate so misaligned strobes simply fall off the top of the bus.
    assign req_strb_d  = ((((2*STRB_W)'(1)) << req_width_d) - (2*STRB_W)'(1)) << req_off_d;

    assign rd_shift_d  = axi_rdata_i >> {addr_q[OFF-1:0], 3'b000};

    always_comb begin
        rd_fmt_d = '0;
        for (int b = 0; b < STRB_W; b++) begin
            if (4'(b) < width_q) begin
                rd_fmt_d[8*b +: 8] = rd_shift_d[8*b +: 8];
            end
        end
    end

`ifdef PROC_MEM_AXI_ERR_EN
    logic [NUM_PORTS-1:0] err_q, err_set_d;

    assign rd_data_d = (axi_rresp_i != 2'b00) ? '0 : rd_fmt_d;

    always_comb begin
        err_set_d = '0;
        if ((state_q == S_RDATA && axi_rvalid_i && axi_rresp_i != 2'b00) ||
            (state_q == S_WRESP && axi_bvalid_i && axi_bresp_i != 2'b00)) begin
            err_set_d[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= '0;
        end else begin
            err_q <= (err_q & ~err_clr_i) | err_set_d;
        end
    end

    assign mem_err_o = err_q;
`else
    logic unused_resp;
    assign rd_data_d   = rd_fmt_d;
    assign unused_resp = ^{axi_rresp_i, axi_bresp_i};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            addr_q    <= '0;
            id_q      <= '0;
            size_q    <= '0;
            width_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            rready_q  <= 1'b0;
            bready_q  <= 1'b0;
            ready_q   <= '0;
            data_q    <= '0;
        end else begin
            ready_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (hit_d) begin
                        grant_q <= grant_d;
                        addr_q  <= req_addr_d;
                        id_q    <= ID_W'(grant_d);
                        size_q  <= width_to_size(req_width_d);
                        width_q <= req_width_d;
                        if (mem_we_i[grant_d]) begin
                            wdata_q   <= req_wdata_d;
                            wstrb_q   <= req_strb_d[STRB_W-1:0];
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= S_WREQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= S_RADDR;
                        end
                    end
                end
                S_RADDR: begin
                    if (axi_arready_i) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (axi_rvalid_i) begin
                        rready_q         <= 1'b0;
                        data_q[grant_q]  <= rd_data_d;
                        ready_q[grant_q] <= 1'b1;
                        state_q          <= S_DONE;
                    end
                end
                S_WREQ: begin
                    if (axi_awready_i) awvalid_q <= 1'b0;
                    if (axi_wready_i)  wvalid_q  <= 1'b0;
                    if ((!awvalid_q || axi_awready_i) && (!wvalid_q || axi_wready_i)) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (axi_bvalid_i) begin
                        bready_q         <= 1'b0;
                        ready_q[grant_q] <= 1'b1;
                        state_q          <= S_DONE;
                    end
                end
                S_DONE: begin
                    ptr_q   <= (grant_q == PW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = ^{axi_rid_i, axi_bid_i, axi_rlast_i};

    assign mem_data_o    = data_q;
    assign mem_ready_o   = ready_q;

    assign axi_awid_o    = id_q;
    assign axi_awaddr_o  = addr_q;
    assign axi_awlen_o   = 8'd0;
    assign axi_awsize_o  = size_q;
    assign axi_awburst_o = 2'b01;
    assign axi_awlock_o  = 1'b0;
    assign axi_awcache_o = 4'b0011;
    assign axi_awprot_o  = 3'b000;
    assign axi_awqos_o   = 4'd0;
    assign axi_awvalid_o = awvalid_q;
    assign axi_wdata_o   = wdata_q;
    assign axi_wstrb_o   = wstrb_q;
    assign axi_wlast_o   = 1'b1;
    assign axi_wvalid_o  = wvalid_q;
    assign axi_bready_o  = bready_q;

    assign axi_arid_o    = id_q;
    assign axi_araddr_o  = addr_q;
    assign axi_arlen_o   = 8'd0;
    assign axi_arsize_o  = size_q;
    assign axi_arburst_o = 2'b01;
    assign axi_arlock_o  = 1'b0;
    assign axi_arcache_o = 4'b0011;
    assign axi_arprot_o  = 3'b000;
    assign axi_arqos_o   = 4'd0;
    assign axi_arvalid_o = arvalid_q;
    assign axi_rready_o  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_proc_mem_axi_arb.sv
`default_nettype none
// =============================================================================
// tb_proc_mem_axi_arb : directed vector bench for proc_mem_axi_arb.
// Revision: 1.0
// =============================================================================
module tb_proc_mem_axi_arb;
    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NP-1:0]          mem_ce = '0, mem_we = '0;
    logic [NP-1:0][AW-1:0]  mem_addr = '0;
    logic [NP-1:0][3:0]     mem_width = '0;
    logic [NP-1:0][DW-1:0]  mem_wdata = '0;
    logic [NP-1:0][DW-1:0]  mem_rdata;
    logic [NP-1:0]          mem_ready;
`ifdef PROC_MEM_AXI_ERR_EN
    logic [NP-1:0]          mem_err;
    logic [NP-1:0]          err_clr = '0;
`endif
    logic [IW-1:0]  awid, arid;
    logic [AW-1:0]  awaddr, araddr;
    logic [7:0]     awlen, arlen;
    logic [2:0]     awsize, arsize, awprot, arprot;
    logic [1:0]     awburst, arburst;
    logic           awlock, arlock;
    logic [3:0]     awcache, arcache, awqos, arqos;
    logic           awvalid, wvalid, wlast, bready, arvalid, rready;
    logic [DW-1:0]  wdata;
    logic [DW/8-1:0] wstrb;
    logic           awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0, rlast = 1;
    logic [1:0]     bresp = 0, rresp = 0;
    logic [IW-1:0]  bid = 0, rid = 0;
    logic [DW-1:0]  rdata = 0;

    proc_mem_axi_arb #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .mem_ce_i(mem_ce), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
        .mem_width_i(mem_width), .mem_data_i(mem_wdata), .mem_data_o(mem_rdata),
        .mem_ready_o(mem_ready),
`ifdef PROC_MEM_AXI_ERR_EN
        .mem_err_o(mem_err), .err_clr_i(err_clr),
`endif
        .axi_awid_o(awid), .axi_awaddr_o(awaddr), .axi_awlen_o(awlen), .axi_awsize_o(awsize),
        .axi_awburst_o(awburst), .axi_awlock_o(awlock), .axi_awcache_o(awcache),
        .axi_awprot_o(awprot), .axi_awqos_o(awqos), .axi_awvalid_o(awvalid),
        .axi_awready_i(awready),
        .axi_wdata_o(wdata), .axi_wstrb_o(wstrb), .axi_wlast_o(wlast),
        .axi_wvalid_o(wvalid), .axi_wready_i(wready),
        .axi_bid_i(bid), .axi_bresp_i(bresp), .axi_bvalid_i(bvalid), .axi_bready_o(bready),
        .axi_arid_o(arid), .axi_araddr_o(araddr), .axi_arlen_o(arlen), .axi_arsize_o(arsize),
        .axi_arburst_o(arburst), .axi_arlock_o(arlock), .axi_arcache_o(arcache),
        .axi_arprot_o(arprot), .axi_arqos_o(arqos), .axi_arvalid_o(arvalid),
        .axi_arready_i(arready),
        .axi_rid_i(rid), .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rlast_i(rlast),
        .axi_rvalid_i(rvalid), .axi_rready_o(rready)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0]  port;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  width;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [2:0]  e_size;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [11];

    logic [AW-1:0]  cap_addr;
    logic [2:0]     cap_size;
    logic [IW-1:0]  cap_id;
    logic [3:0]     cap_strb;
    logic [DW-1:0]  cap_wdata;
    int             cap_ready_n, cap_bv_n, cap_aw_hi, cap_w_hi;

    // One transaction on port p with a responsive AXI slave; awready held off aw_dly cycles.
    task automatic do_txn(input int p, input logic we, input logic [AW-1:0] a, input logic [3:0] w,
                          input logic [DW-1:0] wd, input logic [DW-1:0] rd, input logic [1:0] resp,
                          input int aw_dly);
        int n, aw_cnt;
        bit done;
        n = 0; aw_cnt = 0; done = 0;
        cap_ready_n = 0; cap_bv_n = 0; cap_aw_hi = 0; cap_w_hi = 0;
        cap_addr = '0; cap_size = '0; cap_id = '0; cap_strb = '0; cap_wdata = '0;
        @(negedge clk);
        mem_ce[p] = 1'b1; mem_we[p] = we; mem_addr[p] = a; mem_width[p] = w; mem_wdata[p] = wd;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0; rresp = 0; bresp = 0;
            if (mem_ready[p]) begin
                done = 1; cap_ready_n = n; mem_ce[p] = 1'b0;
            end
            if (arvalid) begin
                cap_addr = araddr; cap_size = arsize; cap_id = arid; arready = 1;
            end
            if (rready) begin
                rvalid = 1; rdata = rd; rresp = resp;
            end
            if (awvalid) begin
                cap_addr = awaddr; cap_size = awsize; cap_id = awid; cap_aw_hi++;
                if (aw_cnt >= aw_dly) awready = 1;
                aw_cnt++;
            end
            if (wvalid) begin
                cap_wdata = wdata; cap_strb = wstrb; cap_w_hi++; wready = 1;
            end
            if (bready) begin
                bvalid = 1; bresp = resp; cap_bv_n = n;
            end
        end
        mem_ce[p] = 1'b0;
        check("txn_completed", 64'(done), 64'd1);
        @(negedge clk);
        check("ready_pulse_width", 64'(mem_ready[p]), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp_order [6];
        int order [8];
        int ngr, nrd, pulse_err, rport, cyc;
        logic [NP-1:0] prev_ready;
        logic seen;

        //            port we  addr          w     wd            rd            size strb     e_wdata       e_rdata
        vecs[0]  = '{4'd2, 1'b0, 32'h1002, 4'd2, 32'h0,        32'hAABBCCDD, 3'd1, 4'b0000, 32'h0,        32'h0000AABB};
        vecs[1]  = '{4'd0, 1'b0, 32'h0100, 4'd4, 32'h0,        32'h12345678, 3'd2, 4'b0000, 32'h0,        32'h12345678};
        vecs[2]  = '{4'd3, 1'b0, 32'h0013, 4'd1, 32'h0,        32'h11223344, 3'd0, 4'b0000, 32'h0,        32'h00000011};
        vecs[3]  = '{4'd1, 1'b1, 32'h0022, 4'd2, 32'h0000BEEF, 32'h0,        3'd1, 4'b1100, 32'hBEEF0000, 32'h0};
        vecs[4]  = '{4'd0, 1'b1, 32'h0040, 4'd4, 32'hCAFEF00D, 32'h0,        3'd2, 4'b1111, 32'hCAFEF00D, 32'h0};
        vecs[5]  = '{4'd2, 1'b1, 32'h0043, 4'd4, 32'h11223344, 32'h0,        3'd2, 4'b1000, 32'h44000000, 32'h0};
        vecs[6]  = '{4'd1, 1'b0, 32'h0006, 4'd4, 32'h0,        32'hAABBCCDD, 3'd2, 4'b0000, 32'h0,        32'h0000AABB};
        vecs[7]  = '{4'd3, 1'b0, 32'h0008, 4'd3, 32'h0,        32'h87654321, 3'd2, 4'b0000, 32'h0,        32'h87654321};
        vecs[8]  = '{4'd0, 1'b1, 32'h0001, 4'd8, 32'h000000AB, 32'h0,        3'd2, 4'b1110, 32'h0000AB00, 32'h0};
        vecs[9]  = '{4'd1, 1'b0, 32'h0005, 4'd2, 32'h0,        32'hF0E1D2C3, 3'd1, 4'b0000, 32'h0,        32'h0000E1D2};
        vecs[10] = '{4'd3, 1'b0, 32'h000B, 4'd2, 32'h0,        32'h99887766, 3'd1, 4'b0000, 32'h0,        32'h00000099};
        exp_order = '{0, 1, 3, 0, 1, 3};

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valids", 64'({arvalid, awvalid, wvalid, rready, bready}), 64'd0);
        check("rst_ready", 64'(mem_ready), 64'd0);
        check("rst_addr_id", 64'({araddr, arid, awid}), 64'd0);
        check("rst_wdata_strb", 64'({wdata, wstrb}), 64'd0);
        check("rst_mem_data", 64'(mem_rdata[0]), 64'd0);
        check("ar_const", 64'({arlen, arburst, arlock, arcache, arprot, arqos}),
              64'({8'h00, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0}));
        check("aw_const", 64'({awlen, awburst, awlock, awcache, awprot, awqos, wlast}),
              64'({8'h00, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0, 1'b1}));
        rst = 1'b1;

        // Table-driven single transactions, zero-wait slave
        for (int i = 0; i < 11; i++) begin
            do_txn(int'(vecs[i].port), vecs[i].we, vecs[i].addr, vecs[i].width,
                   vecs[i].wd, vecs[i].rd, 2'b00, 0);
            check($sformatf("v%0d_latency", i), 64'(cap_ready_n + 1), 64'd4);
            check($sformatf("v%0d_addr", i), 64'(cap_addr), 64'(vecs[i].addr));
            check($sformatf("v%0d_size", i), 64'(cap_size), 64'(vecs[i].e_size));
            check($sformatf("v%0d_id", i), 64'(cap_id), 64'(vecs[i].port));
            if (vecs[i].we) begin
                check($sformatf("v%0d_wdata", i), 64'(cap_wdata), 64'(vecs[i].e_wdata));
                check($sformatf("v%0d_wstrb", i), 64'(cap_strb), 64'(vecs[i].e_strb));
            end else begin
                check($sformatf("v%0d_rdata", i), 64'(mem_rdata[vecs[i].port]), 64'(vecs[i].e_rdata));
            end
        end
        // Port 2 wrote after its read; its read data must be retained
        check("hold_rdata_p2", 64'(mem_rdata[2]), 64'h0000AABB);

        // Reset while arvalid is high, then a stray rvalid
        @(negedge clk);
        mem_ce[0] = 1'b1; mem_we[0] = 1'b0; mem_addr[0] = 32'h200; mem_width[0] = 4'd4;
        @(negedge clk);
        check("mid_arvalid_up", 64'(arvalid), 64'd1);
        rst = 1'b0; mem_ce[0] = 1'b0;
        @(negedge clk);
        check("mid_rst_valids", 64'({arvalid, awvalid, wvalid, rready, bready}), 64'd0);
        check("mid_rst_addr_id", 64'({araddr, arid}), 64'd0);
        check("mid_rst_mem_data", 64'(mem_rdata[2]), 64'd0);
        rst = 1'b1; rvalid = 1; rdata = 32'hDEADBEEF;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (mem_ready != '0 || rready) seen = 1'b1;
        end
        rvalid = 0;
        check("stray_rvalid_ignored", 64'(seen), 64'd0);
        check("stray_rvalid_data", 64'(mem_rdata[0]), 64'd0);

        // Round-robin fairness with ports 0, 1, 3 requesting continuously
        for (int p = 0; p < NP; p++) begin
            mem_we[p] = 1'b0; mem_addr[p] = 32'(p * 16); mem_width[p] = 4'd4;
        end
        mem_ce = 4'b1011;
        ngr = 0; nrd = 0; pulse_err = 0; prev_ready = '0; cyc = 0;
        while (nrd < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            arready = 0; rvalid = 0;
            if ((mem_ready & prev_ready) != '0) pulse_err++;
            prev_ready = mem_ready;
            if (mem_ready != '0) begin
                rport = 0;
                for (int p = 0; p < NP; p++) if (mem_ready[p]) rport = p;
                check($sformatf("rr_ready_port%0d", nrd), 64'(rport), 64'(exp_order[nrd]));
                nrd++;
                if (nrd == 6) mem_ce = '0;
            end
            if (arvalid) begin
                if (ngr < 8) order[ngr] = int'(arid);
                ngr++;
                arready = 1;
            end
            if (rready) begin
                rvalid = 1; rdata = 32'h0BADF00D;
            end
        end
        arready = 0; rvalid = 0; mem_ce = '0;
        check("rr_ready_count", 64'(nrd), 64'd6);
        check("rr_grant_count", 64'(ngr), 64'd6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("rr_grant%0d", k), 64'(order[k]), 64'(exp_order[k]));
        end
        check("rr_pulse_width", 64'(pulse_err), 64'd0);

        // Write with awready delayed 3 cycles, wready immediate
        do_txn(1, 1'b1, 32'h23, 4'd1, 32'h000000EE, 32'h0, 2'b00, 3);
        check("dw_wdata", 64'(cap_wdata), 64'hEE000000);
        check("dw_wstrb", 64'(cap_strb), 64'b1000);
        check("dw_awsize", 64'(cap_size), 64'd0);
        check("dw_awaddr", 64'(cap_addr), 64'h23);
        check("dw_aw_cycles", 64'(cap_aw_hi), 64'd4);
        check("dw_w_cycles", 64'(cap_w_hi), 64'd1);
        check("dw_ready_after_b", 64'(cap_ready_n), 64'(cap_bv_n + 1));
        check("dw_ready_cycle", 64'(cap_ready_n), 64'd6);

        // Error response on a read from port 0
        do_txn(0, 1'b0, 32'h0, 4'd4, 32'h0, 32'h5555AAAA, 2'b10, 0);
`ifdef PROC_MEM_AXI_ERR_EN
        check("err_flag_set", 64'(mem_err[0]), 64'd1);
        check("err_read_zero", 64'(mem_rdata[0]), 64'd0);
        @(negedge clk);
        err_clr[0] = 1'b1;
        @(negedge clk);
        err_clr[0] = 1'b0;
        check("err_flag_clr", 64'(mem_err[0]), 64'd0);
        do_txn(1, 1'b1, 32'h4, 4'd4, 32'h1, 32'h0, 2'b11, 0);
        check("err_bresp_flag", 64'(mem_err), 64'b0010);
`else
        check("resp_ignored_data", 64'(mem_rdata[0]), 64'h5555AAAA);
        do_txn(1, 1'b1, 32'h4, 4'd4, 32'h1, 32'h0, 2'b11, 0);
        check("resp_ignored_wstrb", 64'(cap_strb), 64'b1111);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
